// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive byte capture into a show-ahead FIFO with sticky overflow
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk_50m,
    input  logic                   rst_n,
    input  logic                   rdy,
    input  logic [7:0]             dout,
    output logic                   rdy_clr,
    input  logic                   rd_en,
    output logic [7:0]             rd_data,
    output logic                   rd_valid,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   overflow_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        IDLE,
        WAIT_LOW
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          capture;
    logic          wr_en;
    logic          pop;
    logic          overflow_set;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Capture FSM state register
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture FSM: take one byte per rdy assertion, then wait for the receiver to drop rdy.
    // capture is qualified by rst_n so rdy_clr stays low while reset is held, even if rdy is high.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (rdy) begin
                    capture   = rst_n;
                    state_nxt = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rdy_clr      = capture;
    assign rd_valid     = (count != '0);
    assign full         = (count == CW'(DEPTH));
    assign pop          = rd_en && rd_valid;
    // A full FIFO can still take a byte when the head is popped in the same cycle
    assign wr_en        = capture && (!full || rd_en);
    assign overflow_set = capture && !wr_en;
    assign rd_data      = mem[rd_ptr];

    // Byte storage; not reset, contents are meaningless until written
    always_ff @(posedge clk_50m) begin
        if (wr_en) begin
            mem[wr_ptr] <= dout;
        end
    end

    // Pointers and occupancy count; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag; a new drop takes priority over a clear in the same cycle
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (overflow_set) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

    logic       clk_50m;
    logic       rst_n;
    logic       rdy;
    logic [7:0] dout;
    logic       rdy_clr;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       overflow_clr;

    int total = 0;
    int bad   = 0;

    uart_rx_fifo #(.DEPTH(16)) dut (
        .clk_50m      (clk_50m),
        .rst_n        (rst_n),
        .rdy          (rdy),
        .dout         (dout),
        .rdy_clr      (rdy_clr),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .count        (count),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    initial clk_50m = 1'b0;
    always #10 clk_50m = ~clk_50m;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_50m);
        rdy  = 1'b1;
        dout = b;
        @(negedge clk_50m);
        rdy  = 1'b0;
    endtask

    task automatic pop_byte(output logic [7:0] d);
        @(negedge clk_50m);
        d     = rd_data;
        rd_en = 1'b1;
        @(negedge clk_50m);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rdy = 1'b0; dout = 8'h00; rd_en = 1'b0; overflow_clr = 1'b0;
        #35;
        total++;
        if (count !== 5'd0 || rd_valid !== 1'b0 || full !== 1'b0 || rdy_clr !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: count=%0d rd_valid=%b full=%b rdy_clr=%b overflow=%b, want 0/0/0/0/0",
                     count, rd_valid, full, rdy_clr, overflow);
        end
        @(negedge clk_50m);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk_50m);
        rdy = 1'b1; dout = 8'hA5;
        #1;
        total++;
        if (rdy_clr !== 1'b1 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_capture: rdy_clr=%b rd_valid=%b, want 1/0", rdy_clr, rd_valid);
        end
        @(negedge clk_50m);
        total++;
        if (rdy_clr !== 1'b0 || rd_valid !== 1'b1 || rd_data !== 8'hA5 || count !== 5'd1) begin
            bad++;
            $display("FAIL single_visible: rdy_clr=%b rd_valid=%b rd_data=%h count=%0d, want 0/1/a5/1",
                     rdy_clr, rd_valid, rd_data, count);
        end
        rdy = 1'b0;
        @(negedge clk_50m);
        rd_en = 1'b1;
        @(negedge clk_50m);
        rd_en = 1'b0;
        #1;
        total++;
        if (count !== 5'd0 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_pop: count=%0d rd_valid=%b, want 0/0", count, rd_valid);
        end
    endtask

    task automatic test_slow_clear();
        int pulses = 0;
        logic [7:0] d;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_50m);
            rdy = 1'b1; dout = 8'h3C;
            #1;
            if (rdy_clr === 1'b1) pulses++;
        end
        @(negedge clk_50m);
        rdy = 1'b0;
        #1;
        total++;
        if (pulses != 1 || count !== 5'd1) begin
            bad++;
            $display("FAIL slow_clear: pulses=%0d count=%0d, want 1/1", pulses, count);
        end
        pop_byte(d);
        total++;
        if (d !== 8'h3C) begin
            bad++;
            $display("FAIL slow_clear_data: got %h want 3c", d);
        end
    endtask

    task automatic test_fill_overflow();
        logic [7:0] d;
        int errs = 0;
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        #1;
        total++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL fill_full: full=%b count=%0d overflow=%b, want 1/16/0", full, count, overflow);
        end
        @(negedge clk_50m);
        rdy = 1'b1; dout = 8'h55;
        #1;
        total++;
        if (rdy_clr !== 1'b1) begin
            bad++;
            $display("FAIL overflow_rdy_clr: rdy_clr=%b want 1", rdy_clr);
        end
        @(negedge clk_50m);
        rdy = 1'b0;
        #1;
        total++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            bad++;
            $display("FAIL overflow_set: overflow=%b count=%0d, want 1/16", overflow, count);
        end
        for (int i = 0; i < 16; i++) begin
            pop_byte(d);
            if (d !== 8'(i)) errs++;
        end
        #1;
        total++;
        if (errs != 0 || count !== 5'd0) begin
            bad++;
            $display("FAIL fill_order: data errors=%0d count=%0d, want 0/0", errs, count);
        end
        @(negedge clk_50m);
        overflow_clr = 1'b1;
        @(negedge clk_50m);
        overflow_clr = 1'b0;
        #1;
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL overflow_clear: overflow=%b want 0", overflow);
        end
    endtask

    task automatic test_full_pop_write();
        logic [7:0] d;
        int errs = 0;
        for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i));
        @(negedge clk_50m);
        rdy = 1'b1; dout = 8'h77; rd_en = 1'b1;
        @(negedge clk_50m);
        rdy = 1'b0; rd_en = 1'b0;
        #1;
        total++;
        if (count !== 5'd16 || overflow !== 1'b0 || rd_data !== 8'h11) begin
            bad++;
            $display("FAIL full_pop_write: count=%0d overflow=%b rd_data=%h, want 16/0/11", count, overflow, rd_data);
        end
        for (int i = 1; i < 16; i++) begin
            pop_byte(d);
            if (d !== 8'(8'h10 + i)) errs++;
        end
        pop_byte(d);
        total++;
        if (errs != 0 || d !== 8'h77 || count !== 5'd0) begin
            bad++;
            $display("FAIL full_pop_write_order: errors=%0d last=%h count=%0d, want 0/77/0", errs, d, count);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        logic [7:0] d;
        logic [7:0] b;
        int errs = 0;
        int maxc = 0;
        for (int i = 0; i < 40; i++) begin
            b = 8'((i * 7 + 3) & 8'hFF);
            send_byte(b);
            q.push_back(b);
            #1;
            if (int'(count) > maxc) maxc = int'(count);
            if (int'(count) != q.size()) errs++;
            if (q.size() == 3) begin
                pop_byte(d);
                if (d !== q.pop_front()) errs++;
            end
        end
        while (q.size() != 0) begin
            pop_byte(d);
            if (d !== q.pop_front()) errs++;
        end
        #1;
        total++;
        if (errs != 0 || maxc > 3 || count !== 5'd0) begin
            bad++;
            $display("FAIL wrap: errors=%0d max_count=%0d count=%0d, want 0/<=3/0", errs, maxc, count);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) send_byte(8'(8'hB0 + i));
        @(negedge clk_50m);
        rdy = 1'b1; dout = 8'h99;
        @(negedge clk_50m);
        total++;
        if (count !== 5'd5) begin
            bad++;
            $display("FAIL reset_mid_pre: count=%0d want 5", count);
        end
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (count !== 5'd0 || rd_valid !== 1'b0 || rdy_clr !== 1'b0 || full !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: count=%0d rd_valid=%b rdy_clr=%b full=%b, want 0/0/0/0",
                     count, rd_valid, rdy_clr, full);
        end
        @(negedge clk_50m);
        rst_n = 1'b1;
        #1;
        total++;
        if (rdy_clr !== 1'b1) begin
            bad++;
            $display("FAIL reset_recapture_pulse: rdy_clr=%b want 1", rdy_clr);
        end
        @(negedge clk_50m);
        total++;
        if (count !== 5'd1 || rd_data !== 8'h99 || rdy_clr !== 1'b0) begin
            bad++;
            $display("FAIL reset_recapture: count=%0d rd_data=%h rdy_clr=%b, want 1/99/0", count, rd_data, rdy_clr);
        end
        @(negedge clk_50m);
        total++;
        if (count !== 5'd1) begin
            bad++;
            $display("FAIL reset_recapture_once: count=%0d want 1", count);
        end
        rdy = 1'b0;
        @(negedge clk_50m);
        rd_en = 1'b1;
        @(negedge clk_50m);
        rd_en = 1'b0;
    endtask

    task automatic test_overflow_set_wins();
        logic [7:0] d;
        for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i));
        @(negedge clk_50m);
        rdy = 1'b1; dout = 8'hAA; overflow_clr = 1'b1;
        @(negedge clk_50m);
        rdy = 1'b0; overflow_clr = 1'b0;
        #1;
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_set_wins: overflow=%b want 1", overflow);
        end
        @(negedge clk_50m);
        overflow_clr = 1'b1;
        @(negedge clk_50m);
        overflow_clr = 1'b0;
        #1;
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL overflow_clr_after: overflow=%b want 0", overflow);
        end
        for (int i = 0; i < 16; i++) pop_byte(d);
        @(negedge clk_50m);
        rd_en = 1'b1;
        @(negedge clk_50m);
        rd_en = 1'b0;
        #1;
        total++;
        if (count !== 5'd0 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL empty_pop_ignored: count=%0d rd_valid=%b, want 0/0", count, rd_valid);
        end
        send_byte(8'h42);
        #1;
        total++;
        if (count !== 5'd1 || rd_data !== 8'h42) begin
            bad++;
            $display("FAIL after_empty_pop: count=%0d rd_data=%h, want 1/42", count, rd_data);
        end
        pop_byte(d);
    endtask

    initial begin
        test_reset();
        test_single();
        test_slow_clear();
        test_fill_overflow();
        test_full_pop_write();
        test_wrap();
        test_reset_mid();
        test_overflow_set_wins();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
